// File: rtl/tick_scheduler.sv
`timescale 1ns/1ps
// tick_scheduler: one shared prescaler producing a periodic tick, a
// round-robin arbiter over NCH requesters, and one one-shot delay counter per
// channel counted in prescaler wraps.
// Optional build macro TICK_SCHEDULER_FAST_SIM_EN forces the effective
// prescale to 1 (tick every cycle) for fast simulation.
module tick_scheduler #(
  parameter int NCH      = 4,
  parameter int DW       = 8,
  parameter int PRESCALE = 12000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] dly,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done,
  output logic              tick
);

`ifdef TICK_SCHEDULER_FAST_SIM_EN
  localparam int EFF_PRESCALE = 1;
`else
  localparam int EFF_PRESCALE = PRESCALE;
`endif

  localparam int          PW         = $clog2(NCH);
  localparam logic [31:0] LAST_COUNT = 32'(EFF_PRESCALE - 1);
  localparam logic [PW:0] NCH_W      = (PW + 1)'(NCH);
  localparam logic [PW-1:0] LAST_CH  = PW'(NCH - 1);

  logic [31:0]    count_q, count_d;
  logic           tick_q, tick_d;
  logic           wrap;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [NCH-1:0] busy_vec;
  logic [NCH-1:0] done_vec;
  logic [PW:0]    arb_sum;
  logic [PW-1:0]  arb_idx;
  logic           arb_found;

  // The prescaler wraps on the edge following a cycle spent at the last count.
  assign wrap = (count_q == LAST_COUNT);

  // Prescaler next state: free-running count, tick marks the wrap edge.
  always_comb begin
    count_d = wrap ? 32'd0 : count_q + 32'd1;
    tick_d  = wrap;
  end

  // Prescaler registers; the phase is only ever cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 32'd0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  // Round-robin search from the pointer upward; first idle requester wins.
  always_comb begin
    gnt_d     = '0;
    ptr_d     = ptr_q;
    arb_found = 1'b0;
    arb_sum   = '0;
    arb_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      arb_sum = {1'b0, ptr_q} + (PW + 1)'(k);
      if (arb_sum >= NCH_W) begin
        arb_sum = arb_sum - NCH_W;
      end
      arb_idx = arb_sum[PW-1:0];
      if (!arb_found && req[arb_idx] && !busy_vec[arb_idx]) begin
        arb_found        = 1'b1;
        gnt_d[arb_idx]   = 1'b1;
        ptr_d            = (arb_idx == LAST_CH) ? '0 : arb_idx + 1'b1;
      end
    end
  end

  // Arbiter registers: grant pulse and rotating pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DW-1:0] cnt_q, cnt_d;
    logic          busy_ch_q, busy_ch_d;
    logic          done_ch_q, done_ch_d;

    // Channel next state: load on grant (a coincident wrap is not counted),
    // zero delay expires after one armed cycle, otherwise count down on wraps.
    always_comb begin
      cnt_d     = cnt_q;
      busy_ch_d = busy_ch_q;
      done_ch_d = 1'b0;
      if (gnt_d[gi]) begin
        busy_ch_d = 1'b1;
        cnt_d     = dly[gi*DW +: DW];
      end else if (busy_ch_q) begin
        if (cnt_q == '0) begin
          busy_ch_d = 1'b0;
          done_ch_d = 1'b1;
        end else if (wrap) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DW'(1)) begin
            busy_ch_d = 1'b0;
            done_ch_d = 1'b1;
          end
        end
      end
    end

    // Channel registers; reset aborts without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q     <= '0;
        busy_ch_q <= 1'b0;
        done_ch_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        busy_ch_q <= busy_ch_d;
        done_ch_q <= done_ch_d;
      end
    end

    assign busy_vec[gi] = busy_ch_q;
    assign done_vec[gi] = done_ch_q;
  end

  assign gnt  = gnt_q;
  assign busy = busy_vec;
  assign done = done_vec;
  assign tick = tick_q;

endmodule
